// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction-fetch front end. Issues PCs to a
// variable-latency imem, tags in-order responses with their prediction and
// buffers them in a small fetch queue drained by ID. EX redirects flush the
// queue and discard any responses still in flight.

package if_fetch_queue_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid_if_id;
    } if_id_reg_t;
endpackage

module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned     FQ_DEPTH  = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            fq_valid,
    input  logic            id_ready,
    output if_id_reg_t      if_id_out,
    output logic            fq_pred_taken,
    output logic [XLEN-1:0] fq_pred_target
);
    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned FW = $clog2(FQ_DEPTH);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [0:0] {FETCH, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   kill_cnt;
    logic [CW-1:0]   kill_next;
    logic            req_fire;
    logic            fq_push;
    logic            fq_pop;

    // Pending FIFO: one entry per accepted request, popped by every response
    logic [XLEN-1:0] pend_pc     [MAX_OUTST];
    logic            pend_taken  [MAX_OUTST];
    logic [XLEN-1:0] pend_target [MAX_OUTST];
    logic [PW-1:0]   pend_wr;
    logic [PW-1:0]   pend_rd;

    // Fetch queue storage
    logic [XLEN-1:0] fq_pc     [FQ_DEPTH];
    logic [31:0]     fq_instr  [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc4    [FQ_DEPTH];
    logic            fq_taken  [FQ_DEPTH];
    logic [XLEN-1:0] fq_target [FQ_DEPTH];
    logic [FW-1:0]   fq_head;
    logic [FW-1:0]   fq_tail;
    logic [CW-1:0]   fq_count;

    function automatic logic [PW-1:0] next_pend(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue gating (credit rule reserves an FQ slot per request), handshakes, kill count
    always_comb begin
        fq_valid       = (fq_count != '0);
        imem_req_valid = !reset && (state == FETCH) && !pc_stall && !redirect_valid
                         && (inflight < CW'(MAX_OUTST))
                         && (({1'b0, fq_count} + {1'b0, inflight}) < (CW+1)'(FQ_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        kill_next      = inflight - CW'(imem_resp_valid);
        fq_push        = imem_resp_valid && (state == FETCH) && !redirect_valid;
        fq_pop         = fq_valid && id_ready && !redirect_valid;
    end

    // Fetch PC, in-flight count and FETCH/DRAIN state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            kill_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Nothing issues in DRAIN, so kill_cnt == inflight there; reloading from
                // kill_next keeps the count, minus a response dropped in this cycle.
                fetch_pc <= redirect_target & ~XLEN'(3);
                kill_cnt <= kill_next;
                state    <= (kill_next != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    fetch_pc <= pred_taken ? pred_target : fetch_pc + XLEN'(4);
                end
                if ((state == DRAIN) && imem_resp_valid) begin
                    kill_cnt <= kill_cnt - CW'(1);
                    if (kill_cnt == CW'(1)) begin
                        state <= FETCH;
                    end
                end
            end
        end
    end

    // Pending FIFO: record PC and prediction at issue, release on response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_wr <= '0;
            pend_rd <= '0;
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                pend_pc[i]     <= '0;
                pend_taken[i]  <= 1'b0;
                pend_target[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pend_pc[pend_wr]     <= fetch_pc;
                pend_taken[pend_wr]  <= pred_taken;
                pend_target[pend_wr] <= pred_target;
                pend_wr              <= next_pend(pend_wr);
            end
            if (imem_resp_valid) begin
                pend_rd <= next_pend(pend_rd);
            end
        end
    end

    // Fetch queue: push live responses at tail, pop on ID handshake, flush on redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                fq_pc[i]     <= '0;
                fq_instr[i]  <= '0;
                fq_pc4[i]    <= '0;
                fq_taken[i]  <= 1'b0;
                fq_target[i] <= '0;
            end
        end else if (redirect_valid) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
        end else begin
            if (fq_push) begin
                fq_pc[fq_tail]     <= pend_pc[pend_rd];
                fq_instr[fq_tail]  <= imem_resp_data;
                fq_pc4[fq_tail]    <= pend_pc[pend_rd] + XLEN'(4);
                fq_taken[fq_tail]  <= pend_taken[pend_rd];
                fq_target[fq_tail] <= pend_target[pend_rd];
                fq_tail            <= fq_tail + FW'(1);
            end
            if (fq_pop) begin
                fq_head <= fq_head + FW'(1);
            end
            fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
        end
    end

    // Head entry toward ID and fetch address toward imem/predictor
    always_comb begin
        if_id_out.pc          = fq_pc[fq_head];
        if_id_out.instruction = fq_instr[fq_head];
        if_id_out.pc_plus4    = fq_pc4[fq_head];
        if_id_out.valid_if_id = fq_valid;
        fq_pred_taken         = fq_taken[fq_head];
        fq_pred_target        = fq_target[fq_head];
        pred_pc               = fetch_pc;
        imem_req_addr         = fetch_pc;
    end

    // Every response must belong to an outstanding request; counters stay in bounds
    resp_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (inflight != '0));
    counters_bounded: assert property (@(posedge clk) disable iff (reset)
        (inflight <= CW'(MAX_OUTST)) && (kill_cnt <= inflight));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: imem model with configurable latency, a
// scoreboard of expected FQ entries, and directed fetch/redirect scenarios.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int unsigned FQ_DEPTH  = 4;
    localparam int unsigned MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fq_valid;
    logic        id_ready;
    if_id_reg_t  if_id_out;
    logic        fq_pred_taken;
    logic [31:0] fq_pred_target;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .FQ_DEPTH  (FQ_DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_stall        (pc_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fq_valid        (fq_valid),
        .id_ready        (id_ready),
        .if_id_out       (if_id_out),
        .fq_pred_taken   (fq_pred_taken),
        .fq_pred_target  (fq_pred_target)
    );

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic [31:0] tgt;
        int unsigned due;
        bit          killed;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] tgt;
    } fq_ent_t;

    req_t        pipe[$];
    req_t        cur;
    bit          cur_valid;
    fq_ent_t     expq[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    int unsigned cyc, lat, fire_cnt, resp_cnt, pop_cnt;
    logic [31:0] exp_pc;
    bit          pred_en;
    logic [31:0] pred_hit_pc, pred_hit_tgt;
    int unsigned n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Mid-cycle: check issue and head against the model, then update the scoreboard
    task automatic observe();
        int unsigned infl, nkill;
        bit          exp_rv;
        fq_ent_t     e;
        req_t        r;
        @(negedge clk);
        infl  = pipe.size() + (cur_valid ? 1 : 0);
        nkill = (cur_valid && cur.killed) ? 1 : 0;
        foreach (pipe[i]) if (pipe[i].killed) nkill++;
        exp_rv = !pc_stall && !redirect_valid && (nkill == 0) && (infl < MAX_OUTST)
                 && ((expq.size() + infl) < FQ_DEPTH);
        check_eq("req_valid", imem_req_valid, exp_rv);
        check_eq("fq_valid", fq_valid, expq.size() != 0);
        if (fq_valid && id_ready && !redirect_valid && expq.size() != 0) begin
            e = expq.pop_front();
            check_eq("fq_head",
                {if_id_out.pc, if_id_out.instruction, if_id_out.pc_plus4, fq_pred_target,
                 fq_pred_taken, if_id_out.valid_if_id},
                {e.pc, e.instr, e.pc + 32'd4, e.tgt, e.taken, 1'b1});
            pop_log.push_back(if_id_out.pc);
            pop_cnt++;
        end
        if (cur_valid) begin
            resp_cnt++;
            if (!cur.killed && !redirect_valid) begin
                e.pc    = cur.addr;
                e.instr = cur.addr ^ 32'hDEAD_BEEF;
                e.taken = cur.taken;
                e.tgt   = cur.tgt;
                expq.push_back(e);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_pc);
            r.addr   = imem_req_addr;
            r.taken  = pred_taken;
            r.tgt    = pred_target;
            r.due    = cyc + lat;
            r.killed = 1'b0;
            pipe.push_back(r);
            req_log.push_back(imem_req_addr);
            fire_cnt++;
            exp_pc = pred_taken ? pred_target : exp_pc + 32'd4;
        end
        if (redirect_valid) begin
            expq.delete();
            foreach (pipe[i]) pipe[i].killed = 1'b1;
            exp_pc = redirect_target & 32'hFFFF_FFFC;
        end
    endtask

    // Just after the edge: present the next due response and the predictor result
    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        cur_valid = 1'b0;
        if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            cur       = pipe.pop_front();
            cur_valid = 1'b1;
        end
        imem_resp_valid = cur_valid;
        imem_resp_data  = cur_valid ? (cur.addr ^ 32'hDEAD_BEEF) : 32'h0;
        pred_taken      = pred_en && (pred_pc == pred_hit_pc);
        pred_target     = pred_hit_tgt;
    endtask

    task automatic tick();
        observe();
        advance();
    endtask

    task automatic drain();
        int unsigned n = 0;
        pc_stall = 1'b1;
        id_ready = 1'b1;
        while ((pipe.size() != 0 || cur_valid || expq.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check_eq("drain_done", (pipe.size() != 0 || cur_valid || expq.size() != 0), 1'b0);
        tick();
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0, p0, r0, rc0, kd, n;
        bit          found;
        reset = 1'b1; pc_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        pred_taken = 1'b0; pred_target = '0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b1;
        cur_valid = 1'b0; cyc = 0; lat = 1; fire_cnt = 0; resp_cnt = 0; pop_cnt = 0;
        exp_pc = 32'h0; pred_en = 1'b0; pred_hit_pc = '0; pred_hit_tgt = '0;
        n_checks = 0; n_fail = 0;

        // Reset state
        #12;
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_fq_valid", fq_valid, 1'b0);
        check_eq("rst_if_id", if_id_out, '0);
        check_eq("rst_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 1;

        // 1: sequential fetch, first head visible in cycle 3
        for (int i = 1; i <= 6; i++) begin
            observe();
            if (i <= 2) check_eq("t1_fq_empty", fq_valid, 1'b0);
            if (i == 3) check_eq("t1_first_head", {fq_valid, if_id_out.pc}, {1'b1, 32'h0});
            advance();
        end
        check_eq("t1_addr_seq", {req_log[0], req_log[1], req_log[2]}, {32'h0, 32'h4, 32'h8});

        // 2: ID stalled -> exactly FQ_DEPTH requests, then in-order pops
        drain();
        do_redirect(32'h0);
        id_ready = 1'b0;
        pc_stall = 1'b0;
        f0 = fire_cnt;
        repeat (10) tick();
        check_eq("t2_fire_cnt", fire_cnt - f0, FQ_DEPTH);
        check_eq("t2_req_blocked", imem_req_valid, 1'b0);
        p0 = pop_log.size();
        id_ready = 1'b1;
        repeat (4) tick();
        check_eq("t2_pop_order", {pop_log[p0], pop_log[p0+1], pop_log[p0+2], pop_log[p0+3]},
                 {32'h0, 32'h4, 32'h8, 32'hC});

        // 3: taken prediction at 0x8 -> next fetch 0x40
        drain();
        pred_en = 1'b1; pred_hit_pc = 32'h8; pred_hit_tgt = 32'h40;
        do_redirect(32'h0);
        pc_stall = 1'b0;
        r0 = req_log.size();
        repeat (8) tick();
        check_eq("t3_pred_seq", {req_log[r0+2], req_log[r0+3], req_log[r0+4]},
                 {32'h8, 32'h40, 32'h44});
        pred_en = 1'b0;

        // 4: redirect with two requests in flight and a non-empty FQ
        drain();
        lat = 3;
        id_ready = 1'b0;
        pc_stall = 1'b0;
        n = 0;
        while (!(pipe.size() == 2 && expq.size() != 0 && !cur_valid) && n < 20) begin
            tick();
            n++;
        end
        check_eq("t4_setup", {pipe.size() == 2, expq.size() != 0}, 2'b11);
        r0 = req_log.size();
        rc0 = resp_cnt;
        do_redirect(32'h103);
        observe();
        check_eq("t4_fq_flushed", fq_valid, 1'b0);
        advance();
        n = 0;
        while (req_log.size() == r0 && n < 20) begin
            tick();
            n++;
        end
        check_eq("t4_refetch_addr", req_log[r0], 32'h100);
        check_eq("t4_dropped_resp", resp_cnt - rc0, 2);
        id_ready = 1'b1;

        // 5: redirect coincident with a response and an ID pop
        drain();
        pc_stall = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            id_ready = ($urandom_range(0, 1) != 0);
            if (imem_resp_valid && fq_valid && id_ready && pipe.size() != 0) found = 1'b1;
        end
        check_eq("t5_window_found", found, 1'b1);
        if (found) begin
            kd  = pipe.size();
            rc0 = resp_cnt;
            r0  = req_log.size();
            do_redirect(32'h300);
            id_ready = 1'b1;
            observe();
            check_eq("t5_fq_flushed", fq_valid, 1'b0);
            advance();
            n = 0;
            while (req_log.size() == r0 && n < 20) begin
                tick();
                n++;
            end
            check_eq("t5_refetch_addr", req_log[r0], 32'h300);
            check_eq("t5_kill_count", resp_cnt - rc0, kd + 1);
        end

        // 6: PC wrap, then pc_stall blocks issue while the FQ keeps draining
        drain();
        lat = 1;
        do_redirect(32'hFFFF_FFFC);
        pc_stall = 1'b0;
        id_ready = 1'b0;
        r0 = req_log.size();
        repeat (4) tick();
        check_eq("t6_wrap", {req_log[r0], req_log[r0+1]}, {32'hFFFF_FFFC, 32'h0});
        pc_stall = 1'b1;
        id_ready = 1'b1;
        p0 = pop_cnt;
        f0 = fire_cnt;
        repeat (3) tick();
        check_eq("t6_stall_no_req", fire_cnt - f0, 0);
        check_eq("t6_stall_pops", pop_cnt - p0, 3);

        drain();
        check_eq("end_fq_empty", fq_valid, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
